// File: rtl/rx_accesscode_corr_if.sv
// Bit-stream, configuration and status signals of the receive access-code correlator.
// The master side drives bits and configuration; the slave side is the correlator.
interface rx_accesscode_corr_if #(
  parameter int CORR_W = 7,
  parameter int WIN_W  = 10
);
  logic              p_1us;
  logic              rxen;
  logic              rx_start_p;
  logic              rxdata_in;
  logic [63:0]       regi_syncword;
  logic [CORR_W-1:0] regi_corr_threshold;
  logic [WIN_W-1:0]  regi_search_win;
  logic              rx_trailer_st_p;
  logic [CORR_W-1:0] sync_corr_peak;
  logic              trailer_err;
  logic              rx_timeout_p;
  logic              rxbit;
  logic              rxbit_valid_p;
  logic              rx_busy;

  modport master (
    output p_1us, rxen, rx_start_p, rxdata_in,
           regi_syncword, regi_corr_threshold, regi_search_win,
    input  rx_trailer_st_p, sync_corr_peak, trailer_err, rx_timeout_p,
           rxbit, rxbit_valid_p, rx_busy
  );

  modport slave (
    input  p_1us, rxen, rx_start_p, rxdata_in,
           regi_syncword, regi_corr_threshold, regi_search_win,
    output rx_trailer_st_p, sync_corr_peak, trailer_err, rx_timeout_p,
           rxbit, rxbit_valid_p, rx_busy
  );
endinterface

// File: rtl/rx_accesscode_corr.sv
// Receive access-code correlator: slides a 64-bit window over the bit stream,
// detects the sync word, checks the 4-bit trailer and forwards aligned data bits.
module rx_accesscode_corr #(
  parameter int CORR_W = 7,
  parameter int WIN_W  = 10
) (
  input  logic                clk_6M,
  input  logic                rstz,
  rx_accesscode_corr_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEARCH  = 2'd1;
  localparam logic [1:0] TRAILER = 2'd2;
  localparam logic [1:0] DATA    = 2'd3;

  localparam logic [CORR_W-1:0] WIN_FULL = CORR_W'(64);

  logic [1:0]        state;
  logic [63:0]       shreg;
  logic [CORR_W-1:0] fill_cnt;
  logic [CORR_W-1:0] corr;
  logic [CORR_W-1:0] corr_q;
  logic [CORR_W-1:0] peak_q;
  logic [WIN_W-1:0]  timer;
  logic [1:0]        trl_cnt;
  logic              shift_q;
  logic              eval_q;
  logic              full_q;
  logic              match;
  logic              timeout_hit;
  logic              trl_exp;
  logic              trl_st_q;
  logic              timeout_q;
  logic              trl_err_q;
  logic              rxbit_q;
  logic              valid_q;

  // NOTE: give every always_comb output a value before any loop or branch so no latch is inferred.
  always_comb begin
    corr = '0;
    for (int i = 0; i < 64; i++) begin
      corr = corr + CORR_W'(~(shreg[i] ^ bus.regi_syncword[i]));
    end
  end

  // eval_q marks the single clk where corr_q/full_q reflect the newest bit, so
  // match and timeout are judged on the same bit and match takes priority.
  assign match       = (state == SEARCH) && eval_q && full_q &&
                       (corr_q >= bus.regi_corr_threshold);
  assign timeout_hit = (state == SEARCH) && eval_q && (bus.regi_search_win != '0) &&
                       (timer == bus.regi_search_win);
  assign trl_exp     = trl_cnt[0] ? bus.regi_syncword[63] : ~bus.regi_syncword[63];

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state     <= IDLE;
      shreg     <= '0;
      fill_cnt  <= '0;
      corr_q    <= '0;
      peak_q    <= '0;
      timer     <= '0;
      trl_cnt   <= '0;
      shift_q   <= 1'b0;
      eval_q    <= 1'b0;
      full_q    <= 1'b0;
      trl_st_q  <= 1'b0;
      timeout_q <= 1'b0;
      trl_err_q <= 1'b0;
      rxbit_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      trl_st_q  <= 1'b0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      shift_q   <= 1'b0;
      eval_q    <= shift_q;
      corr_q    <= corr;
      full_q    <= (fill_cnt == WIN_FULL);
      if (!bus.rxen) begin
        state  <= IDLE;
        eval_q <= 1'b0;
        full_q <= 1'b0;
      end else if (bus.rx_start_p) begin
        state     <= SEARCH;
        shreg     <= '0;
        fill_cnt  <= '0;
        timer     <= '0;
        trl_cnt   <= '0;
        trl_err_q <= 1'b0;
        eval_q    <= 1'b0;
        full_q    <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (match) begin
              state    <= TRAILER;
              peak_q   <= corr_q;
              trl_st_q <= 1'b1;
              trl_cnt  <= '0;
            end else if (timeout_hit) begin
              state     <= IDLE;
              timeout_q <= 1'b1;
            end else if (bus.p_1us) begin
              shreg   <= {bus.rxdata_in, shreg[63:1]};
              timer   <= timer + WIN_W'(1);
              shift_q <= 1'b1;
              if (fill_cnt != WIN_FULL) fill_cnt <= fill_cnt + CORR_W'(1);
            end
          end
          TRAILER: begin
            if (bus.p_1us) begin
              if (bus.rxdata_in != trl_exp) trl_err_q <= 1'b1;
              trl_cnt <= trl_cnt + 2'd1;
              if (trl_cnt == 2'd3) state <= DATA;
            end
          end
          DATA: begin
            if (bus.p_1us) begin
              rxbit_q <= bus.rxdata_in;
              valid_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_trailer_st_p = trl_st_q;
  assign bus.sync_corr_peak  = peak_q;
  assign bus.trailer_err     = trl_err_q;
  assign bus.rx_timeout_p    = timeout_q;
  assign bus.rxbit           = rxbit_q;
  assign bus.rxbit_valid_p   = valid_q;
  assign bus.rx_busy         = (state != IDLE);
endmodule

// File: doc/rx_accesscode_corr.md
Name: rx_accesscode_corr

Overview:
- Receive-side front end of the baseband bit processor.
- Slides a 64-bit window over the demodulated 1 Mb/s bit stream and correlates it against the expected sync word.
- On a match it verifies the 4-bit trailer and issues rx_trailer_st_p, then forwards aligned header/payload bits to the header and payload bit processors.
- It is the receive counterpart of the tx access-code/header/payload bit generation path.

Parameters:
- CORR_W, 7, width of the agreement count (0..64).
- WIN_W, 10, width of the search-window timer in us.

Ports:
- clk_6M  input  1  system clock, 6 MHz.
- rstz  input  1  asynchronous active-low reset.
- p_1us  input  1  one-clk_6M strobe per received bit.
- rxen  input  1  receiver enable; low forces IDLE.
- rx_start_p  input  1  start/restart a search.
- rxdata_in  input  1  demodulated bit, sampled on p_1us.
- regi_syncword  input  64  expected sync word; bit 0 is received first.
- regi_corr_threshold  input  7  minimum agreeing bits for a match.
- regi_search_win  input  WIN_W  search timeout in us; 0 = unlimited.
- rx_trailer_st_p  output  1  one-clk pulse marking the trailer start.
- sync_corr_peak  output  CORR_W  agreement count latched at match.
- trailer_err  output  1  sticky trailer-mismatch flag.
- rx_timeout_p  output  1  one-clk pulse when the search window expires.
- rxbit  output  1  registered, aligned received bit.
- rxbit_valid_p  output  1  one-clk strobe qualifying rxbit.
- rx_busy  output  1  high in SEARCH, TRAILER and DATA.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register, bit counter and timer cleared.
- States: IDLE, SEARCH, TRAILER, DATA.
- IDLE -> SEARCH on rx_start_p with rxen=1. Entry clears the shift register, the fill counter (saturating at 64), the timer and trailer_err.
- SEARCH, per p_1us:
  - Shift right, with the new bit entering bit 63.
  - Increment the fill counter.
  - Increment the timer.
- Correlation:
  - corr = popcount(~(shreg ^ regi_syncword)), computed combinationally.
  - corr is registered one clk after the shift, as corr_q.
- Match condition: state SEARCH, fill counter = 64, corr_q >= regi_corr_threshold.
  - Threshold values above 64 never match.
  - Threshold 0 matches as soon as the window is full.
- Match action:
  - Latch sync_corr_peak = corr_q.
  - Go to TRAILER.
  - Pulse rx_trailer_st_p one clk later, i.e. 2 clk after the p_1us that sampled sync bit 63.
- Timeout: when regi_search_win != 0 and the timer equals regi_search_win with no match, pulse rx_timeout_p and go to IDLE. A match on that same bit wins over the timeout.
- TRAILER:
  - Sample 4 bits on p_1us.
  - Expected pattern is 1010 (first to last) if regi_syncword[63]=0, else 0101.
  - Any mismatching bit sets trailer_err, which stays set until the next SEARCH entry.
  - After the 4th bit go to DATA. Trailer bits do not produce rxbit_valid_p.
- DATA: each p_1us registers rxdata_in into rxbit and pulses rxbit_valid_p on the next clk. DATA persists until rxen=0 or rx_start_p.
- rx_start_p in any non-IDLE state restarts SEARCH with all clears applied; no valid, trailer or timeout pulse is emitted for the aborted attempt.
- rxen=0 forces IDLE within one clk and suppresses all pulses. This overrides a simultaneous rx_start_p.
- Asynchronous reset mid-operation returns to the reset values immediately. No pulse may fire in the first clk after rstz deasserts.
- sync_corr_peak holds its value until the next match or reset.

Test Plan:
- Exact match: syncword 64'hB5_3C_2E_91_47_0D_F6_A8 sent LSB first, threshold 64, trailer 0101 → rx_trailer_st_p exactly 2 clk after the 64th p_1us; sync_corr_peak=64; trailer_err=0; first rxbit_valid_p after the 4th trailer bit.
- Threshold margin: same word with 7 bit errors → match at threshold 57 (peak 57); no match at threshold 58.
- Timeout: regi_search_win=100, random bits with no match → rx_timeout_p on the 100th p_1us; state IDLE; rx_busy=0.
- Trailer error: correct sync word, trailer 0111 with syncword[63]=1 → trailer_err=1; DATA still entered; trailer_err cleared by the next rx_start_p.
- Restart and abort: rx_start_p at bit 40 of a sync word → no match from the partial word, detection only after 64 fresh bits. rxen=0 during TRAILER → IDLE, no rxbit_valid_p.
- Fill guard: threshold 0 → no match before 64 bits, then a match on the 64th bit. Reset asserted in DATA → all outputs 0.
